mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port program/data memory (m_addr/m_data/m_wren/m_q) between two
//  requesters: port 0 = processor (P1 fetch, P4 load/store), port 1 = loader/debug/IO.
//  Fixed priority to port 0, with a starvation guard that forces a port-1 grant.
//  Every memory access uses a registered req/ack handshake. Read latency is programmable.
// PARAMETERS
//  AW         12  memory address width
//  DW         16  memory data width
//  RD_LAT      1  cycles from m_addr registered to valid m_q (1 = synchronous RAM); >=1
//  STARVE_MAX  4  consecutive port-0 grants allowed while req1 is pending; >=1
// PORTS
//  clock    in   1   system clock, rising edge
//  reset    in   1   asynchronous, active-high
//  req0     in   1   port-0 request; addr0/wdata0/wren0 stable while req0 high
//  wren0    in   1   port-0 write (1) / read (0)
//  addr0    in   AW  port-0 address
//  wdata0   in   DW  port-0 write data
//  ack0     out  1   one-cycle completion pulse to port 0
//  req1/wren1/addr1/wdata1/ack1  same as port 0, for port 1
//  rdata    out  DW  read data = m_q; valid only in an ack cycle of a read
//  owner    out  1   port being served (valid while busy)
//  busy     out  1   high in ACCESS and WAIT
//  m_q      in   DW  memory read data
//  m_addr   out  AW  memory address (registered)
//  m_data   out  DW  memory write data (registered)
//  m_wren   out  1   memory write enable (registered)
// BEHAVIOUR
//  Reset (async): state=IDLE; m_addr=0, m_data=0, m_wren=0, ack0=ack1=0, owner=0, busy=0,
//   starve_cnt=0. An access cut by reset is abandoned: no ack, m_wren low at once.
//  FSM states: IDLE, ACCESS, WAIT, DONE.
//  IDLE: if req0|req1 at the edge, pick the winner and latch its addr/wdata/wren into m_*.
//   Set owner and busy. Go to ACCESS. With no request, stay in IDLE with m_wren=0.
//  Arbitration:
//   - Only one requesting port: that port wins.
//   - Both requesting: port 0 wins, unless starve_cnt==STARVE_MAX; then port 1 wins.
//  starve_cnt (saturating):
//   - +1 on each port-0 grant made while req1 is high.
//   - Cleared on a port-1 grant, or in any IDLE cycle with req1 low.
//  ACCESS, write: memory writes at the end of this cycle. The ack pulse is issued in this
//   same cycle. Next state DONE, with m_wren cleared at that edge.
//  ACCESS, read: m_wren=0. If RD_LAT==1, go to DONE. Otherwise go to WAIT with lat_cnt=1.
//  WAIT: lat_cnt increments each cycle. When lat_cnt==RD_LAT-1, go to DONE.
//  Read ack: registered, asserted in the DONE cycle; rdata=m_q is valid in that cycle.
//  DONE: busy=0. Ack is high for reads only. Always returns to IDLE.
//  Write ack: asserted in the ACCESS cycle only, never in DONE.
//  Latency (request seen in IDLE cycle T):
//   - Write: ack in T+1, next grant possible in T+3.
//   - Read: ack in T+1+RD_LAT.
//  Only one ack is ever high, only for owner, and exactly one ack per granted transaction.
//  A requester deasserting req mid-transaction does not abort it; the ack is still issued.
//  A req still high in the IDLE cycle after an ack is treated as a new transaction.
//  The non-granted request is held pending and is never dropped. m_* are stable for the
//   whole transaction.
//  Address/data are used unmodified; there is no wrap or width conversion.
// TESTING
//  1 Port-0 write addr0=12'h010, wdata0=16'hBEEF -> m_wren=1 for exactly one cycle with
//    m_addr=12'h010, m_data=16'hBEEF; ack0 in T+1; ack1 never asserted.
//  2 Port-1 read of 12'h010 after test 1, RD_LAT=1 -> ack1 in T+2, rdata=16'hBEEF;
//    repeat with RD_LAT=3 -> ack1 in T+4.
//  3 req0 and req1 held high continuously, STARVE_MAX=4 -> grant order 0,0,0,0,1,0,0,0,0,1,...
//    with no lost or duplicate acks.
//  4 req1 only, with back-to-back reads to 12'h000..12'h003 -> one ack per read;
//    rdata matches preloaded memory; one IDLE cycle between transactions.
//  5 Assert reset during ACCESS of a port-0 write -> m_wren=0 and ack0=0 immediately;
//    memory word unchanged if reset precedes the write edge; FSM in IDLE after release.
//  6 Drop req0 in the cycle after its grant (read) -> transaction completes; ack0 still
//    pulses once; then the FSM idles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between two requesters.
//   Port 0 (processor) has fixed priority. A starvation guard forces a port-1 grant once
//   STARVE_MAX consecutive port-0 grants have been made while port 1 was waiting.
//   Each access is a req/ack handshake. The memory-side address, data and write enable
//   are registered and held stable for the whole transaction.
// Ports:
//   clk_i, rst_i               clock (rising edge), asynchronous active-high reset
//   reqN_i, wrenN_i            port N request and write(1)/read(0) select
//   addrN_i, wdataN_i          port N address and write data, stable while reqN_i is high
//   ackN_o                     one-cycle completion pulse to port N
//   rdata_o                    read data (m_q_i), valid in the ack cycle of a read
//   owner_o                    port being served, valid while busy_o is high
//   busy_o                     high in ACCESS and WAIT
//   m_q_i                      memory read data
//   m_addr_o, m_data_o         registered memory address and write data
//   m_wren_o                   registered memory write enable
module mem_arbiter #(
  parameter int unsigned AW         = 12,
  parameter int unsigned DW         = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic          wren0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [DW-1:0] wdata0_i,
  output logic          ack0_o,
  input  logic          req1_i,
  input  logic          wren1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          ack1_o,
  output logic [DW-1:0] rdata_o,
  output logic          owner_o,
  output logic          busy_o,
  input  logic [DW-1:0] m_q_i,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_data_o,
  output logic          m_wren_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

  localparam int unsigned LatW    = $clog2(RD_LAT + 1);
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  localparam logic [LatW-1:0]    LatLast   = LatW'(RD_LAT - 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

  state_e              state_q, state_d;
  logic [AW-1:0]       m_addr_q, m_addr_d;
  logic [DW-1:0]       m_data_q, m_data_d;
  logic                m_wren_q, m_wren_d;
  // Transaction type survives m_wren being dropped after the write cycle.
  logic                wr_q, wr_d;
  logic                owner_q, owner_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic [LatW-1:0]     lat_q, lat_d;

  logic pick1;
  logic ack_any;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      m_addr_q <= '0;
      m_data_q <= '0;
      m_wren_q <= 1'b0;
      wr_q     <= 1'b0;
      owner_q  <= 1'b0;
      starve_q <= '0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      m_addr_q <= m_addr_d;
      m_data_q <= m_data_d;
      m_wren_q <= m_wren_d;
      wr_q     <= wr_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      lat_q    <= lat_d;
    end
  end

  // Port 1 wins when it is alone, or when port 0 has used up its starvation allowance.
  assign pick1 = req1_i & (~req0_i | (starve_q == StarveMax));

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    m_addr_d = m_addr_q;
    m_data_d = m_data_q;
    m_wren_d = m_wren_q;
    wr_d     = wr_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    lat_d    = lat_q;
    unique case (state_q)
      StIdle: begin
        m_wren_d = 1'b0;
        if (!req1_i) starve_d = '0;
        if (req0_i | req1_i) begin
          state_d  = StAccess;
          owner_d  = pick1;
          m_addr_d = pick1 ? addr1_i  : addr0_i;
          m_data_d = pick1 ? wdata1_i : wdata0_i;
          m_wren_d = pick1 ? wren1_i  : wren0_i;
          wr_d     = pick1 ? wren1_i  : wren0_i;
          if (pick1) begin
            starve_d = '0;
          end else if (req1_i && (starve_q != StarveMax)) begin
            starve_d = starve_q + StarveW'(1);
          end
        end
      end
      StAccess: begin
        m_wren_d = 1'b0;
        if (wr_q || (RD_LAT == 1)) begin
          state_d = StDone;
        end else begin
          state_d = StWait;
          lat_d   = LatW'(1);
        end
      end
      StWait: begin
        if (lat_q == LatLast) begin
          state_d = StDone;
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: writes ack in ACCESS (the write edge), reads ack in DONE (data valid).
  always_comb begin
    ack_any  = ((state_q == StAccess) & wr_q) | ((state_q == StDone) & ~wr_q);
    ack0_o   = ack_any & ~owner_q;
    ack1_o   = ack_any & owner_q;
    busy_o   = (state_q == StAccess) | (state_q == StWait);
    owner_o  = owner_q;
    rdata_o  = m_q_i;
    m_addr_o = m_addr_q;
    m_data_o = m_data_q;
    m_wren_o = m_wren_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: dut_a uses RD_LAT=1, dut_b uses RD_LAT=3.
// Each DUT has a small synchronous memory model with matching read latency.
module tb_mem_arbiter;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst;
  logic preload;

  logic          a_req0, a_wren0, a_req1, a_wren1;
  logic [AW-1:0] a_addr0, a_addr1;
  logic [DW-1:0] a_wdata0, a_wdata1;
  logic          a_ack0, a_ack1, a_owner, a_busy, a_m_wren;
  logic [DW-1:0] a_rdata, a_m_q, a_m_data;
  logic [AW-1:0] a_m_addr;

  logic          b_req0, b_wren0, b_req1, b_wren1;
  logic [AW-1:0] b_addr0, b_addr1;
  logic [DW-1:0] b_wdata0, b_wdata1;
  logic          b_ack0, b_ack1, b_owner, b_busy, b_m_wren;
  logic [DW-1:0] b_rdata, b_m_q, b_m_data, b_q1, b_q2;
  logic [AW-1:0] b_m_addr;

  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;
  int n_ack = 0;
  int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .STARVE_MAX(4)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req0_i(a_req0), .wren0_i(a_wren0), .addr0_i(a_addr0), .wdata0_i(a_wdata0), .ack0_o(a_ack0),
    .req1_i(a_req1), .wren1_i(a_wren1), .addr1_i(a_addr1), .wdata1_i(a_wdata1), .ack1_o(a_ack1),
    .rdata_o(a_rdata), .owner_o(a_owner), .busy_o(a_busy), .m_q_i(a_m_q),
    .m_addr_o(a_m_addr), .m_data_o(a_m_data), .m_wren_o(a_m_wren)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req0_i(b_req0), .wren0_i(b_wren0), .addr0_i(b_addr0), .wdata0_i(b_wdata0), .ack0_o(b_ack0),
    .req1_i(b_req1), .wren1_i(b_wren1), .addr1_i(b_addr1), .wdata1_i(b_wdata1), .ack1_o(b_ack1),
    .rdata_o(b_rdata), .owner_o(b_owner), .busy_o(b_busy), .m_q_i(b_m_q),
    .m_addr_o(b_m_addr), .m_data_o(b_m_data), .m_wren_o(b_m_wren)
  );

  // Synchronous RAM, one cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4; i++) mem_a[AW'(i)] <= 16'hA000 + 16'(i);
      mem_a[12'h020] <= 16'h1234;
    end else if (a_m_wren) begin
      mem_a[a_m_addr] <= a_m_data;
    end
    a_m_q <= mem_a[a_m_addr];
  end

  // RAM with three cycles of read latency.
  always @(posedge clk) begin
    if (b_m_wren) mem_b[b_m_addr] <= b_m_data;
    b_q1  <= mem_b[b_m_addr];
    b_q2  <= b_q1;
    b_m_q <= b_q2;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; preload = 1'b1;
    a_req0 = 0; a_wren0 = 0; a_addr0 = '0; a_wdata0 = '0;
    a_req1 = 0; a_wren1 = 0; a_addr1 = '0; a_wdata1 = '0;
    b_req0 = 0; b_wren0 = 0; b_addr0 = '0; b_wdata0 = '0;
    b_req1 = 0; b_wren1 = 0; b_addr1 = '0; b_wdata1 = '0;
    tick; tick;
    // Reset state
    check("rst_m_addr", a_m_addr, 0);
    check("rst_m_data", a_m_data, 0);
    check("rst_m_wren", a_m_wren, 0);
    check("rst_acks", {a_ack0, a_ack1}, 0);
    check("rst_owner", a_owner, 0);
    check("rst_busy", a_busy, 0);
    preload = 1'b0; rst = 1'b0;
    tick;

    // Test 1: port-0 write on both DUTs
    a_req0 = 1; a_wren0 = 1; a_addr0 = 12'h010; a_wdata0 = 16'hBEEF;
    b_req0 = 1; b_wren0 = 1; b_addr0 = 12'h010; b_wdata0 = 16'hBEEF;
    check("t1_idle_busy", a_busy, 0);
    tick;
    check("t1_m_wren", a_m_wren, 1);
    check("t1_m_addr", a_m_addr, 12'h010);
    check("t1_m_data", a_m_data, 16'hBEEF);
    check("t1_ack0", a_ack0, 1);
    check("t1_ack1", a_ack1, 0);
    check("t1_busy", a_busy, 1);
    check("t1_b_ack0", b_ack0, 1);
    a_req0 = 0; b_req0 = 0;
    tick;
    check("t1_done_wren", a_m_wren, 0);
    check("t1_done_ack0", a_ack0, 0);
    check("t1_done_busy", a_busy, 0);
    check("t1_mem", mem_a[12'h010], 16'hBEEF);
    tick;
    check("t1_idle_ack", {a_ack0, a_ack1}, 0);

    // Test 2a: port-1 read, RD_LAT=1
    a_req1 = 1; a_wren1 = 0; a_addr1 = 12'h010;
    tick;
    check("t2a_access_ack1", a_ack1, 0);
    check("t2a_owner", a_owner, 1);
    check("t2a_busy", a_busy, 1);
    a_req1 = 0;
    tick;
    check("t2a_ack1", a_ack1, 1);
    check("t2a_rdata", a_rdata, 16'hBEEF);
    check("t2a_ack0", a_ack0, 0);
    tick;
    check("t2a_after_ack1", a_ack1, 0);

    // Test 2b: port-1 read, RD_LAT=3 (ack expected in T+4)
    b_req1 = 1; b_wren1 = 0; b_addr1 = 12'h010;
    tick;
    check("t2b_t1_ack1", b_ack1, 0);
    b_req1 = 0;
    tick;
    check("t2b_t2_ack1", b_ack1, 0);
    check("t2b_t2_busy", b_busy, 1);
    tick;
    check("t2b_t3_ack1", b_ack1, 0);
    check("t2b_t3_busy", b_busy, 1);
    tick;
    check("t2b_t4_ack1", b_ack1, 1);
    check("t2b_t4_rdata", b_rdata, 16'hBEEF);
    check("t2b_t4_busy", b_busy, 0);
    tick;
    check("t2b_t5_ack1", b_ack1, 0);

    // Test 3: both ports requesting continuously
    a_req0 = 1; a_wren0 = 0; a_addr0 = 12'h000;
    a_req1 = 1; a_wren1 = 0; a_addr1 = 12'h001;
    n_ack = 0;
    for (int c = 0; c < 40 && n_ack < 10; c++) begin
      tick;
      check("t3_ack_excl", a_ack0 & a_ack1, 0);
      if (a_ack0 | a_ack1) begin
        check("t3_order", a_ack1, exp_seq[n_ack]);
        check("t3_rdata", a_rdata, (exp_seq[n_ack] == 1) ? 16'hA001 : 16'hA000);
        n_ack++;
      end
    end
    a_req0 = 0; a_req1 = 0;
    check("t3_ack_count", n_ack, 10);
    tick;
    tick;
    check("t3_idle_busy", a_busy, 0);
    check("t3_idle_acks", {a_ack0, a_ack1}, 0);

    // Test 4: back-to-back port-1 reads of 0..3
    a_req1 = 1; a_wren1 = 0; a_addr1 = 12'h000;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("t4_access_addr", a_m_addr, i);
      check("t4_access_ack", a_ack1, 0);
      tick;
      check("t4_ack1", a_ack1, 1);
      check("t4_rdata", a_rdata, 16'hA000 + i);
      a_addr1 = AW'(i + 1);
      if (i == 3) a_req1 = 0;
      tick;
      check("t4_idle_busy", a_busy, 0);
      check("t4_idle_ack", a_ack1, 0);
    end
    tick;
    check("t4_end_busy", a_busy, 0);

    // Test 5: reset during the ACCESS cycle of a port-0 write
    a_req0 = 1; a_wren0 = 1; a_addr0 = 12'h020; a_wdata0 = 16'h5555;
    tick;
    check("t5_pre_wren", a_m_wren, 1);
    rst = 1; a_req0 = 0;
    #1;
    check("t5_rst_wren", a_m_wren, 0);
    check("t5_rst_ack0", a_ack0, 0);
    check("t5_rst_busy", a_busy, 0);
    check("t5_rst_maddr", a_m_addr, 0);
    tick;
    rst = 0;
    check("t5_mem_kept", mem_a[12'h020], 16'h1234);
    tick;
    check("t5_post_busy", a_busy, 0);
    check("t5_post_acks", {a_ack0, a_ack1}, 0);
    a_req1 = 1; a_wren1 = 0; a_addr1 = 12'h020;
    tick;
    check("t5_new_busy", a_busy, 1);
    a_req1 = 0;
    tick;
    check("t5_new_ack1", a_ack1, 1);
    check("t5_new_rdata", a_rdata, 16'h1234);
    tick;

    // Test 6: port-0 read with req dropped after grant
    a_req0 = 1; a_wren0 = 0; a_addr0 = 12'h003;
    tick;
    check("t6_access_busy", a_busy, 1);
    check("t6_access_owner", a_owner, 0);
    a_req0 = 0;
    tick;
    check("t6_ack0", a_ack0, 1);
    check("t6_rdata", a_rdata, 16'hA003);
    tick;
    check("t6_after_ack0", a_ack0, 0);
    check("t6_after_busy", a_busy, 0);
    tick;
    tick;
    check("t6_idle_busy", a_busy, 0);
    check("t6_idle_acks", {a_ack0, a_ack1}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
